// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG encoder output path.
// Holds the bit packer FSM states, byte constants and lane-mask helper.
package jpeg_enc_pkg;

  localparam int unsigned ACC_W   = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CODE_W  = 16;
  localparam int unsigned WIDTH_W = 5;
  localparam int unsigned LANES   = 4;

  localparam logic [WIDTH_W-1:0] JPEG_MAX_WIDTH   = 5'd16;
  localparam logic [7:0]         JPEG_STUFF_BYTE  = 8'h00;
  localparam logic [7:0]         JPEG_MARKER_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LAST   = 2'd2
  } bp_state_t;

  // Strobe for the lanes strictly below the lane pointer.
  function automatic logic [LANES-1:0] lanes_below(input logic [1:0] ptr);
    case (ptr)
      2'd0:    lanes_below = 4'b0000;
      2'd1:    lanes_below = 4'b0001;
      2'd2:    lanes_below = 4'b0011;
      default: lanes_below = 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/jpeg_bitpacker_word.sv
// Byte-in to 32-bit word-out assembler; the lane register doubles as the
// output word register, so a held word blocks further lane writes.
module jpeg_bitpacker_word
  import jpeg_enc_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_wr,
  input  logic [7:0]         i_byte,
  input  logic               i_final,
  input  logic               i_finish,
  input  logic               i_accept,
  output logic               o_free_c,
  output logic               o_empty_next_c,
  output logic               o_valid,
  output logic [ACC_W-1:0]   o_data,
  output logic [LANES-1:0]   o_strb,
  output logic               o_last
);

  logic               r_valid, r_last;
  logic [ACC_W-1:0]   r_data;
  logic [LANES-1:0]   r_strb;
  logic [1:0]         r_ptr;

  logic               w_pop, w_valid, w_last;
  logic [ACC_W-1:0]   w_data;
  logic [LANES-1:0]   w_strb, w_below;
  logic [1:0]         w_ptr;

  assign w_pop    = r_valid && i_accept;
  assign o_free_c = !r_valid || i_accept;

  // A handshake frees the register first, so a lane-0 write can follow at once.
  always_comb begin
    w_valid = r_valid && !i_accept;
    w_last  = r_last && !i_accept;
    w_strb  = w_pop ? '0 : r_strb;
    w_data  = w_pop ? '0 : r_data;
    w_ptr   = r_ptr;
    w_below = lanes_below(r_ptr);
    if (i_wr && o_free_c) begin
      w_data[{r_ptr, 3'b000} +: 8] = i_byte;
      if (r_ptr == 2'd3 || i_final) begin
        w_valid = 1'b1;
        w_last  = i_final;
        w_strb  = {w_below[2:0], 1'b1};
        w_ptr   = 2'd0;
      end else begin
        w_ptr = r_ptr + 2'd1;
      end
    end else if (i_finish) begin
      if (r_valid && !i_accept) begin
        w_last = 1'b1;
      end else begin
        w_valid = 1'b1;
        w_last  = 1'b1;
        w_strb  = w_below;
        w_ptr   = 2'd0;
      end
    end
    o_empty_next_c = !w_valid && (w_ptr == 2'd0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_strb  <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_strb  <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else begin
      r_valid <= w_valid;
      r_last  <= w_last;
      r_strb  <= w_strb;
      r_data  <= w_data;
      r_ptr   <= w_ptr;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_strb  = r_strb;
  assign o_last  = r_last;

endmodule

// File: rtl/jpeg_bitpacker.sv
// Encoder bit packer: MSB-first code accumulator, 0xFF byte stuffing,
// 1-padding on flush and 32-bit word output with strobes and last flag.
module jpeg_bitpacker
  import jpeg_enc_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               img_start_i,
  input  logic               inport_valid_i,
  input  logic [CODE_W-1:0]  inport_data_i,
  input  logic [WIDTH_W-1:0] inport_width_i,
  input  logic               inport_flush_i,
  output logic               inport_accept_o,
  output logic               outport_valid_o,
  output logic [ACC_W-1:0]   outport_data_o,
  output logic [LANES-1:0]   outport_strb_o,
  output logic               outport_last_o,
  input  logic               outport_accept_i,
  output logic               idle_o
);

  bp_state_t          r_state, w_state;
  logic [ACC_W-1:0]   r_acc, w_acc, w_acc_pad, w_pad_mask, w_bits, w_app;
  logic [CNT_W-1:0]   r_cnt, w_cnt, w_cnt_pad, w_cnt_rnd, w_shamt;
  logic               r_stuff, w_stuff, r_idle;
  logic [WIDTH_W-1:0] w_width;
  logic [7:0]         w_byte;
  logic               w_take, w_pad, w_lane_free, w_wr_stuff, w_extract, w_wr;
  logic               w_ending, w_final, w_finish, w_word_empty_next;

  // Accumulator datapath, stuffing and next-state logic.
  always_comb begin
    w_width         = (inport_width_i > JPEG_MAX_WIDTH) ? JPEG_MAX_WIDTH : inport_width_i;
    inport_accept_o = (r_state == ST_ACTIVE) && (r_cnt <= 6'd16);
    w_take          = inport_valid_i && inport_accept_o;
    w_bits  = 32'(inport_data_i & 16'((17'd1 << w_width) - 17'd1));
    w_shamt = 6'd32 - r_cnt - 6'(w_width);
    w_app   = w_take ? (w_bits << w_shamt) : '0;

    // Padding only ever applies on the first DRAIN cycle; afterwards cnt is byte aligned.
    w_pad      = (r_state == ST_DRAIN) && (r_cnt[2:0] != 3'd0);
    w_cnt_rnd  = {r_cnt[5:3] + 3'd1, 3'b000};
    w_pad_mask = (32'hFFFF_FFFF >> r_cnt) & ~(32'hFFFF_FFFF >> w_cnt_rnd);
    w_acc_pad  = w_pad ? (r_acc | w_pad_mask) : r_acc;
    w_cnt_pad  = w_pad ? w_cnt_rnd : r_cnt;

    w_wr_stuff = r_stuff && w_lane_free;
    w_extract  = !r_stuff && w_lane_free && (w_cnt_pad >= 6'd8);
    w_wr       = w_wr_stuff || w_extract;
    w_byte     = w_wr_stuff ? JPEG_STUFF_BYTE : w_acc_pad[31:24];

    w_acc = w_acc_pad | w_app;
    if (w_extract) w_acc = w_acc << 8;
    w_cnt = w_cnt_pad + (w_take ? 6'(w_width) : 6'd0) - (w_extract ? 6'd8 : 6'd0);

    w_stuff = r_stuff;
    if (w_wr_stuff) w_stuff = 1'b0;
    else if (w_extract && (w_byte == JPEG_MARKER_BYTE)) w_stuff = 1'b1;

    // The byte that empties the scan closes the word in the same write.
    w_ending = (r_state == ST_DRAIN) || (w_take && inport_flush_i);
    w_final  = w_ending && w_wr && (w_cnt == 6'd0) && !w_stuff;
    w_finish = (r_state == ST_DRAIN) && !w_wr && (w_cnt_pad == 6'd0) && !r_stuff;

    w_state = r_state;
    case (r_state)
      ST_ACTIVE: if (w_take && inport_flush_i) w_state = w_final ? ST_LAST : ST_DRAIN;
      ST_DRAIN:  if (w_final || w_finish) w_state = ST_LAST;
      ST_LAST:   if (outport_valid_o && outport_accept_i) w_state = ST_ACTIVE;
      default:   w_state = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_ACTIVE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_stuff <= 1'b0;
      r_idle  <= 1'b1;
    end else if (img_start_i) begin
      r_state <= ST_ACTIVE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_stuff <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_acc   <= w_acc;
      r_cnt   <= w_cnt;
      r_stuff <= w_stuff;
      r_idle  <= (w_state == ST_ACTIVE) && (w_cnt == 6'd0) && !w_stuff && w_word_empty_next;
    end
  end

  assign idle_o = r_idle;

  jpeg_bitpacker_word u_word (
    .i_clk          (clk_i),
    .i_rst_n        (rst_i),
    .i_clear        (img_start_i),
    .i_wr           (w_wr),
    .i_byte         (w_byte),
    .i_final        (w_final),
    .i_finish       (w_finish),
    .i_accept       (outport_accept_i),
    .o_free_c       (w_lane_free),
    .o_empty_next_c (w_word_empty_next),
    .o_valid        (outport_valid_o),
    .o_data         (outport_data_o),
    .o_strb         (outport_strb_o),
    .o_last         (outport_last_o)
  );

endmodule

// File: tb/tb_jpeg_bitpacker.sv
// Directed bench for jpeg_bitpacker: hand-computed scans, a modelled
// random-width stream with output back-pressure, and reset/restart checks.
module tb_jpeg_bitpacker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        img_start_i = 1'b0;
  logic        inport_valid_i = 1'b0;
  logic [15:0] inport_data_i = '0;
  logic [4:0]  inport_width_i = '0;
  logic        inport_flush_i = 1'b0;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic [3:0]  outport_strb_o;
  logic        outport_last_o;
  logic        outport_accept_i = 1'b1;
  logic        idle_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rx_data[$];
  logic [3:0]  rx_strb[$];
  logic        rx_last[$];
  logic [7:0]  rx_bytes[$];
  logic [7:0]  exp_bytes[$];
  bit          mq[$];
  logic        got_last = 1'b0;
  logic        hold_win = 1'b0;
  logic        saw_block = 1'b0;

  jpeg_bitpacker dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .img_start_i      (img_start_i),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_width_i   (inport_width_i),
    .inport_flush_i   (inport_flush_i),
    .inport_accept_o  (inport_accept_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_strb_o   (outport_strb_o),
    .outport_last_o   (outport_last_o),
    .outport_accept_i (outport_accept_i),
    .idle_o           (idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Capture words whose handshake completes on the coming rising edge.
  always @(negedge clk_i) begin
    if (rst_i && !img_start_i && outport_valid_o && outport_accept_i) begin
      rx_data.push_back(outport_data_o);
      rx_strb.push_back(outport_strb_o);
      rx_last.push_back(outport_last_o);
      for (int i = 0; i < 4; i++)
        if (outport_strb_o[i]) rx_bytes.push_back(outport_data_o[8*i +: 8]);
      if (outport_last_o) got_last = 1'b1;
    end
    if (hold_win && !inport_accept_o) saw_block = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rx();
    rx_data.delete(); rx_strb.delete(); rx_last.delete(); rx_bytes.delete();
    exp_bytes.delete(); mq.delete();
    got_last = 1'b0;
  endtask

  // Present one code and hold it until taken; called at posedge+1.
  task automatic send(input logic [15:0] d, input logic [4:0] w, input logic f);
    int n = 0;
    int wc;
    inport_valid_i = 1'b1; inport_data_i = d; inport_width_i = w; inport_flush_i = f;
    forever begin
      @(negedge clk_i);
      if (inport_accept_o) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 32'(inport_accept_o), 32'd1);
        break;
      end
    end
    @(posedge clk_i); #1;
    inport_valid_i = 1'b0; inport_flush_i = 1'b0;
    wc = (w > 5'd16) ? 16 : int'(w);
    for (int i = wc - 1; i >= 0; i--) mq.push_back(d[i]);
  endtask

  task automatic model_finish();
    logic [7:0] b;
    while (mq.size() % 8 != 0) mq.push_back(1'b1);
    while (mq.size() > 0) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], mq.pop_front()};
      exp_bytes.push_back(b);
      if (b == 8'hFF) exp_bytes.push_back(8'h00);
    end
  endtask

  task automatic wait_last();
    int n = 0;
    while (!got_last && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("last_seen", 32'(got_last), 32'd1);
  endtask

  // Single-word scan: check the one word and the return to idle.
  task automatic check_scan(input string tag, input logic [31:0] ed, input logic [3:0] es);
    wait_last();
    chk({tag, "_words"}, 32'(rx_data.size()), 32'd1);
    if (rx_data.size() > 0) begin
      chk({tag, "_data"}, rx_data[0], ed);
      chk({tag, "_strb"}, 32'(rx_strb[0]), 32'(es));
      chk({tag, "_last"}, 32'(rx_last[0]), 32'd1);
    end
    repeat (2) @(posedge clk_i); #1;
    chk({tag, "_idle"}, 32'(idle_o), 32'd1);
    clear_rx();
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(outport_valid_o), 32'd0);
    chk("rst_data", outport_data_o, 32'd0);
    chk("rst_strb", 32'(outport_strb_o), 32'd0);
    chk("rst_last", 32'(outport_last_o), 32'd0);
    chk("rst_accept", 32'(inport_accept_o), 32'd1);
    chk("rst_idle", 32'(idle_o), 32'd1);
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;

    send(16'hFFFD, 5'd3, 1'b0); send(16'h001F, 5'd5, 1'b0); send(16'h0000, 5'd0, 1'b1);
    check_scan("t1", 32'h0000_00BF, 4'b0001);

    send(16'h00FF, 5'd8, 1'b0); send(16'h0012, 5'd8, 1'b1);
    check_scan("t2", 32'h0012_00FF, 4'b0111);

    send(16'h0000, 5'd3, 1'b1);
    check_scan("t3a", 32'h0000_001F, 4'b0001);
    send(16'h0007, 5'd3, 1'b1);
    check_scan("t3b", 32'h0000_00FF, 4'b0011);

    send(16'hABCD, 5'd16, 1'b0); send(16'h1234, 5'd16, 1'b1);
    check_scan("t4", 32'h3412_CDAB, 4'b1111);

    send(16'h1234, 5'd31, 1'b1);
    check_scan("clamp", 32'h0000_3412, 4'b0011);

    send(16'h0000, 5'd0, 1'b1);
    check_scan("empty", 32'h0000_0000, 4'b0000);

    // Modelled random-width stream with a 20-cycle output stall.
    clear_rx();
    saw_block = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          send(16'($urandom), 5'($urandom_range(16, 0)), k == 39);
      end
      begin
        repeat (8) @(posedge clk_i);
        #1 outport_accept_i = 1'b0; hold_win = 1'b1;
        repeat (20) @(posedge clk_i);
        #1 outport_accept_i = 1'b1; hold_win = 1'b0;
      end
    join
    wait_last();
    model_finish();
    chk("rand_len", 32'(rx_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++)
      chk($sformatf("rand_byte%0d", i), 32'(rx_bytes[i]), 32'(exp_bytes[i]));
    chk("rand_last_end", 32'(rx_last[rx_last.size()-1]), 32'd1);
    chk("rand_last_cnt", 32'(rx_last.sum() with (int'(item))), 32'd1);
    chk("rand_block", 32'(saw_block), 32'd1);
    repeat (2) @(posedge clk_i); #1;
    chk("rand_idle", 32'(idle_o), 32'd1);
    clear_rx();

    // Asynchronous reset while draining with a held word.
    outport_accept_i = 1'b0;
    send(16'hABCD, 5'd16, 1'b0); send(16'h1234, 5'd16, 1'b0); send(16'h0056, 5'd8, 1'b1);
    repeat (3) @(posedge clk_i); #1;
    chk("drain_valid", 32'(outport_valid_o), 32'd1);
    chk("drain_data", outport_data_o, 32'h3412_CDAB);
    chk("drain_last", 32'(outport_last_o), 32'd0);
    chk("drain_accept", 32'(inport_accept_o), 32'd0);
    chk("drain_idle", 32'(idle_o), 32'd0);
    rst_i = 1'b0; #1;
    chk("arst_valid", 32'(outport_valid_o), 32'd0);
    chk("arst_data", outport_data_o, 32'd0);
    chk("arst_strb", 32'(outport_strb_o), 32'd0);
    chk("arst_last", 32'(outport_last_o), 32'd0);
    chk("arst_accept", 32'(inport_accept_o), 32'd1);
    chk("arst_idle", 32'(idle_o), 32'd1);
    @(negedge clk_i); rst_i = 1'b1; outport_accept_i = 1'b1;
    @(posedge clk_i); #1;
    clear_rx();

    // img_start wins over a simultaneous input handshake.
    img_start_i = 1'b1; inport_valid_i = 1'b1; inport_data_i = 16'h00FF; inport_width_i = 5'd8;
    @(posedge clk_i); #1;
    img_start_i = 1'b0; inport_valid_i = 1'b0;
    chk("start_idle", 32'(idle_o), 32'd1);
    chk("start_accept", 32'(inport_accept_o), 32'd1);
    chk("start_valid", 32'(outport_valid_o), 32'd0);
    send(16'h0000, 5'd0, 1'b1);
    check_scan("start_empty", 32'h0000_0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
